ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
Parametrised successor to the single-port Hack-style RAM. It provides a width- and depth-parametrised word memory with:
- one write/read port (A) and one independent read-only port (B);
- a hardware clear sequencer that zeroes every word after reset or on request, one word per cycle, with a busy flag.
It sits between the CPU/data path and any second reader (screen/debug) in the memory subsystem.

Parameters:
WIDTH, 16, data word width in bits
SIZE, 8, number of words; any value >= 2, need not be a power of two
AW (localparam), $clog2(SIZE), address width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset; starts a clear sweep
in  input  WIDTH  write data, port A
load  input  1  write enable, port A
address  input  AW  read/write address, port A
out  output  WIDTH  combinational read data, port A
address_b  input  AW  read address, port B
out_b  output  WIDTH  combinational read data, port B
clear  input  1  synchronous soft-clear request (same sweep as reset)
busy  output  1  high while the clear sweep runs

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- State machine has two states, IDLE and CLEAR. Counter clr_addr is AW bits wide.
- Reset:
  - Edge with reset=1: state<=CLEAR, clr_addr<=0, no memory write. This holds for every state, including mid-sweep, where the sweep restarts at 0.
- CLEAR state, edge with reset=0:
  - mem[clr_addr]<=0, clr_addr<=clr_addr+1.
  - If clr_addr==SIZE-1: state<=IDLE, clr_addr<=0.
  - The sweep therefore takes exactly SIZE edges after reset deasserts.
- IDLE state:
  - Edge with clear=1 (reset=0): state<=CLEAR, clr_addr<=0; no write that cycle, even if load=1.
  - clear is ignored while in CLEAR.
- busy: combinational, busy = (state==CLEAR). It is 1 from the first edge with reset=1 until the edge that completes the sweep.
- Writes:
  - Edge in IDLE with load=1, clear=0, reset=0 and address<SIZE: mem[address]<=in.
  - Writes with address>=SIZE are dropped.
  - load is ignored while busy.
- Reads:
  - out = mem[address] and out_b = mem[address_b], combinational, zero-latency.
  - A write becomes visible on both ports immediately after the write edge.
  - Before that edge, ports show the old contents; see the optional feature for the exception.
- Out-of-range reads: address>=SIZE drives 0 on the corresponding port.
- While busy=1: out and out_b are forced to 0, regardless of partially cleared contents.
- Power-up: contents and state are undefined until the first reset; reset is mandatory.
- Both ports may read the same address simultaneously, with identical results.
- Widths: no arithmetic on data; clr_addr comparison is against SIZE-1 at AW bits, so no wrap occurs for non-power-of-two SIZE.

Optional Feature:
Macro: RAM_DP_WRITE_THROUGH_EN
- Defined: in IDLE with load=1 and address<SIZE, out=in combinationally in the cycle before the edge. out_b=in when additionally address_b==address. This is a write-through bypass; the busy forcing to 0 still has priority.
- Undefined: both ports show stored contents until the write edge, as described under Behaviour.

Test Plan:
All scenarios use SIZE=8, WIDTH=16, clk period 10.
1. Reset: reset=1 for 1 cycle, then 0. busy=1 for exactly 8 following cycles, then 0; sweep all addresses on both ports -> out=out_b=0.
2. Write/read: load=1, address=1, in=11111 for one edge; then load=1, address=3, in=3333, address_b=1. After the edges: out=3333, out_b=11111. Address 7 reads 0 until written with 7777, then reads 7777 on both ports.
3. Write timing (macro off): load=1, address=address_b=5, in=555. Before the edge, out=out_b=0; after the edge, out=out_b=555. With the macro on, both ports read 555 before the edge.
4. Soft clear: after scenario 2, pulse clear=1 together with load=1, address=2, in=222. No write to address 2; busy=1 for 8 cycles; out forced 0 meanwhile. Afterwards addresses 1, 3, 7 read 0 and address 2 reads 0.
5. Reset mid-sweep: pulse clear, then assert reset on the 4th busy cycle. busy stays 1 for 8 cycles after reset deasserts; all words read 0. A load=1 issued during busy leaves memory unchanged.
6. Non-power-of-two depth: SIZE=6, AW=3, reset. Sweep lasts 6 cycles. Write address=6, in=1234 -> ignored; out with address=6 reads 0, and address 0..5 read 0.

Source files
------------

// File: rtl/ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_clr
// Brief    : Dual-port word RAM (A: read/write, B: read-only) with a hardware
//            clear sweep after reset or on request. Optional write-through
//            bypass when RAM_DP_WRITE_THROUGH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_clr #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 8,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [AW-1:0]    address,
  output logic [WIDTH-1:0] out,
  input  logic [AW-1:0]    address_b,
  output logic [WIDTH-1:0] out_b,
  input  logic             clear,
  output logic             busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Range checks run one bit wider so a power-of-two SIZE does not wrap.
  localparam logic [AW:0]   c_size = (AW + 1)'(SIZE);
  localparam logic [AW-1:0] c_last = AW'(SIZE - 1);

  logic [WIDTH-1:0] r_mem [SIZE];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_clr_addr;
  logic [AW-1:0]    w_clr_addr_nxt;

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_a_in_range;
  logic             w_b_in_range;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_a_in_range = ({1'b0, address}   < c_size);
  assign w_b_in_range = ({1'b0, address_b} < c_size);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Next state and the single memory write port (sweep or port A).
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_we           = 1'b0;
    w_waddr        = address;
    w_wdata        = in;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
        w_wdata = '0;
        if (r_clr_addr == c_last) begin
          w_state_nxt    = S_IDLE;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end else if (load && w_a_in_range) begin
          w_we = 1'b1;
        end
      end
    endcase
    if (reset) begin
      w_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign busy = (r_state == S_CLEAR);

`ifdef RAM_DP_WRITE_THROUGH_EN
  logic w_bypass;
  assign w_bypass = (r_state == S_IDLE) && load && w_a_in_range;
  assign w_rd_a   = w_bypass ? in : r_mem[address];
  assign w_rd_b   = (w_bypass && (address_b == address)) ? in : r_mem[address_b];
`else
  assign w_rd_a   = r_mem[address];
  assign w_rd_b   = r_mem[address_b];
`endif

  // Partially cleared contents are never exposed while the sweep runs.
  assign out   = (busy || !w_a_in_range) ? '0 : w_rd_a;
  assign out_b = (busy || !w_b_in_range) ? '0 : w_rd_b;

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dp_clr
// Brief    : Self-checking bench for ram_dp_clr (SIZE=8 and SIZE=6 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dp_clr;

`ifdef RAM_DP_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0, clear = 1'b0, load = 1'b0;
  logic [15:0] in = '0;
  logic [2:0]  address = '0, address_b = '0;
  logic [15:0] out, out_b;
  logic        busy;

  logic        reset6 = 1'b0, clear6 = 1'b0, load6 = 1'b0;
  logic [15:0] in6 = '0;
  logic [2:0]  address6 = '0, address_b6 = '0;
  logic [15:0] out6, out_b6;
  logic        busy6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_dp_clr #(.WIDTH(16), .SIZE(8)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .address(address),
    .out(out), .address_b(address_b), .out_b(out_b), .clear(clear), .busy(busy)
  );

  ram_dp_clr #(.WIDTH(16), .SIZE(6)) dut6 (
    .clk(clk), .reset(reset6), .in(in6), .load(load6), .address(address6),
    .out(out6), .address_b(address_b6), .out_b(out_b6), .clear(clear6), .busy(busy6)
  );

  // Reference model: a sweep is visible only as "busy, then all zero", so
  // the whole array is zeroed at sweep start and a countdown tracks busy.
  logic [15:0] model [8];
  int          left = 0;
  bit          model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_a();
    if (left > 0) return 16'd0;
    if (WT && load) return in;
    return model[address];
  endfunction

  function automatic logic [15:0] exp_b();
    if (left > 0) return 16'd0;
    if (WT && load && address_b == address) return in;
    return model[address_b];
  endfunction

  task automatic model_edge();
    if (reset) begin
      foreach (model[i]) model[i] = '0;
      left = 8;
    end else if (left > 0) begin
      left--;
    end else if (clear) begin
      foreach (model[i]) model[i] = '0;
      left = 8;
    end else if (load) begin
      model[address] = in;
    end
  endtask

  task automatic apply(input logic rs, input logic cl, input logic ld,
                       input logic [2:0] a, input logic [15:0] d, input logic [2:0] ab);
    reset = rs; clear = cl; load = ld; address = a; in = d; address_b = ab;
    #4;
  endtask

  task automatic edge_update();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    if (model_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, left > 0});
      chk("out", {16'd0, out}, {16'd0, exp_a()});
      chk("out_b", {16'd0, out_b}, {16'd0, exp_b()});
    end
  endtask

  task automatic step(input logic rs, input logic cl, input logic ld,
                      input logic [2:0] a, input logic [15:0] d, input logic [2:0] ab);
    apply(rs, cl, ld, a, d, ab);
    check_model();
    edge_update();
  endtask

  // Runs edges while busy (optionally with a load attempt) and returns the count.
  task automatic count_busy(input logic ld, output int n);
    n = 0;
    while (busy && n < 100) begin
      step(1'b0, 1'b0, ld, 3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)));
      n++;
    end
  endtask

  typedef struct {
    logic        ld;
    logic [2:0]  a;
    logic [15:0] d;
    logic [2:0]  ab;
    logic [15:0] eo;
    logic [15:0] eob;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n;
    vecs[0] = '{1'b1, 3'd1, 16'd11111, 3'd1, WT ? 16'd11111 : 16'd0, WT ? 16'd11111 : 16'd0};
    vecs[1] = '{1'b1, 3'd3, 16'd3333,  3'd1, WT ? 16'd3333 : 16'd0,  16'd11111};
    vecs[2] = '{1'b0, 3'd3, 16'd0,     3'd1, 16'd3333,               16'd11111};
    vecs[3] = '{1'b0, 3'd7, 16'd0,     3'd7, 16'd0,                  16'd0};
    vecs[4] = '{1'b1, 3'd7, 16'd7777,  3'd3, WT ? 16'd7777 : 16'd0,  16'd3333};
    vecs[5] = '{1'b0, 3'd7, 16'd0,     3'd7, 16'd7777,               16'd7777};
    vecs[6] = '{1'b1, 3'd5, 16'd555,   3'd5, WT ? 16'd555 : 16'd0,   WT ? 16'd555 : 16'd0};
    vecs[7] = '{1'b0, 3'd5, 16'd0,     3'd5, 16'd555,                16'd555};
    vecs[8] = '{1'b0, 3'd1, 16'd0,     3'd3, 16'd11111,              16'd3333};

    @(posedge clk); #1;

    // Reset and initial sweep
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 3'd0);
    model_valid = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_out", {16'd0, out}, 32'd0);
    count_busy(1'b0, n);
    chk("reset_sweep_len", n, 32'd8);
    for (int a = 0; a < 8; a++) begin
      apply(1'b0, 1'b0, 1'b0, 3'(a), 16'd0, 3'(7 - a));
      chk("post_reset_out", {16'd0, out}, 32'd0);
      chk("post_reset_out_b", {16'd0, out_b}, 32'd0);
      edge_update();
    end

    // Table vectors: pre-edge outputs, then commit the edge
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 1'b0, vecs[i].ld, vecs[i].a, vecs[i].d, vecs[i].ab);
      chk($sformatf("vec%0d_out", i), {16'd0, out}, {16'd0, vecs[i].eo});
      chk($sformatf("vec%0d_out_b", i), {16'd0, out_b}, {16'd0, vecs[i].eob});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
      edge_update();
    end

    // Soft clear with a simultaneous load that must be dropped
    step(1'b0, 1'b1, 1'b1, 3'd2, 16'd222, 3'd2);
    chk("clear_busy", {31'd0, busy}, 32'd1);
    count_busy(1'b0, n);
    chk("clear_sweep_len", n, 32'd8);
    foreach (vecs[i]) begin end
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ra;
      ra = (k == 0) ? 3'd1 : (k == 1) ? 3'd3 : (k == 2) ? 3'd7 : 3'd2;
      apply(1'b0, 1'b0, 1'b0, ra, 16'd0, ra);
      chk("after_clear_out", {16'd0, out}, 32'd0);
      chk("after_clear_out_b", {16'd0, out_b}, 32'd0);
      edge_update();
    end

    // Reset on the 4th busy cycle of a soft-clear sweep, loads during busy
    step(1'b0, 1'b0, 1'b1, 3'd4, 16'd4444, 3'd4);
    step(1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 3'd4);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 3'd4, 16'd99, 3'd4);
    chk("mid_sweep_busy", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 3'd0);
    count_busy(1'b1, n);
    chk("restart_sweep_len", n, 32'd8);
    for (int a = 0; a < 8; a++) begin
      apply(1'b0, 1'b0, 1'b0, 3'(a), 16'd0, 3'(a));
      chk("after_restart_out", {16'd0, out}, 32'd0);
      edge_update();
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), 1'($urandom),
           3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)));
    end

    // Non-power-of-two depth (SIZE=6)
    apply(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 3'd0);
    reset6 = 1'b1;
    @(posedge clk); #1;
    reset6 = 1'b0;
    chk("s6_reset_busy", {31'd0, busy6}, 32'd1);
    chk("s6_reset_out", {16'd0, out6}, 32'd0);
    n = 0;
    while (busy6 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s6_sweep_len", n, 32'd6);
    load6 = 1'b1; address6 = 3'd6; address_b6 = 3'd6; in6 = 16'd1234;
    #4;
    chk("s6_oor_pre_out", {16'd0, out6}, 32'd0);
    chk("s6_oor_pre_out_b", {16'd0, out_b6}, 32'd0);
    @(posedge clk); #1;
    address6 = 3'd5; in6 = 16'd55;
    @(posedge clk); #1;
    load6 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address6 = 3'(a); address_b6 = 3'(a);
      #1;
      chk("s6_read_out", {16'd0, out6}, (a == 5) ? 32'd55 : 32'd0);
      chk("s6_read_out_b", {16'd0, out_b6}, (a == 5) ? 32'd55 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
